mul_seq_unit: RTL and testbench
===============================

MUL_SEQ_UNIT -- requirements
Module: mul_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; even values only.
REQ-002 SHALL have port Clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port iStart  input  1  request pulse; operands sampled with it.
REQ-005 SHALL have port iA  input  WIDTH  multiplicand (unsigned).
REQ-006 SHALL have port iB  input  WIDTH  multiplier (unsigned).
REQ-007 SHALL have port oBusy  output  1  high while a request is in progress (RUN or DONE).
REQ-008 SHALL have port oDone  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port oResult  output  2*WIDTH  product; held until the next accepted request.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE.
REQ-011 In IDLE or DONE, iStart=1 at a posedge SHALL be accepted: capture iA and iB, clear accumulator, load the step counter, go to RUN.
REQ-012 In RUN, iStart SHALL be ignored; operands SHALL NOT be re-sampled.
REQ-013 Each RUN cycle SHALL consume the k LSBs of the multiplier register (k=1 radix-2, k=2 radix-4): add the selected partial product to the accumulator, shift the multiplier right k bits, shift the multiplicand left k bits.
REQ-014 Radix-2 partial product SHALL be 0 or A; radix-4 SHALL be 0, A, 2A or 3A; 3A is formed once at accept time.
REQ-015 Accumulator and shifted multiplicand SHALL be 2*WIDTH bits wide; no overflow is possible and none is flagged.
REQ-016 RUN SHALL last exactly N cycles, N=WIDTH (radix-2) or WIDTH/2 (radix-4); latency is fixed, with no early exit on zero operands.
REQ-017 After the last RUN cycle the FSM SHALL enter DONE for exactly one cycle with oDone=1; oResult SHALL update on that same edge.
REQ-018 oDone SHALL rise exactly N+1 posedges after the accepting posedge.
REQ-019 DONE with iStart=0 SHALL return to IDLE; DONE with iStart=1 SHALL accept back-to-back per REQ-011.
REQ-020 oResult SHALL change only on entry to DONE and on Reset.
REQ-021 oBusy SHALL be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-022 Reset=1 at a posedge SHALL force IDLE, oBusy=0, oDone=0, oResult=0, accumulator=0, counter=0, regardless of state.
REQ-023 Reset SHALL take priority over iStart in the same cycle; the request SHALL be dropped.
REQ-024 Reset mid-RUN SHALL abort the request with no oDone pulse.

Configuration
REQ-025 Macro MUL_RADIX4_EN SHALL select the step width.
REQ-026 With MUL_RADIX4_EN defined, the unit SHALL retire 2 bits per cycle (N=WIDTH/2) and include the 3A register and the 4-way partial-product select.
REQ-027 Without MUL_RADIX4_EN, the unit SHALL retire 1 bit per cycle (N=WIDTH) with a 2-way select and no 3A register.
REQ-028 oResult values SHALL be identical in both builds; only the latency differs.

Structure
REQ-029 State encodings (IDLE/RUN/DONE) and the per-build step-count constant SHALL live in the shared definitions file with the opcode defines.
REQ-030 The partial-product select SHALL be a sub-module mul_pp_select: inputs A, 2A, 3A and a 2-bit selector, output one partial product; the radix-2 build uses selector {1'b0, bit}.
REQ-031 The FSM, counter and datapath registers SHALL stay in mul_seq_unit.

Verification
REQ-032 Radix-2, WIDTH=16: iA=3, iB=5, iStart pulse -> oDone high 17 cycles later, oResult=0x0000000F, oBusy=1 for 17 cycles.
REQ-033 Corner values: 0xFFFF*0xFFFF -> 0xFFFE0001; 0*0x1234 -> 0 with the full fixed latency; 0x8000*2 -> 0x00010000.
REQ-034 iStart re-pulsed with iA=7, iB=7 during RUN -> ignored; first result returned; no second oDone.
REQ-035 Reset asserted 4 cycles into RUN -> next cycle oBusy=0, oResult=0; no oDone follows.
REQ-036 iStart held high in DONE with iA=2, iB=9 -> back-to-back accept; second oDone 17 cycles later with oResult=0x12; first result visible until then.
REQ-037 MUL_RADIX4_EN build, 0x00FF*0x0101 -> oDone 9 cycles after accept, oResult=0x0000FFFF; random-operand compare against a reference product in both builds.

Source files
------------

// File: rtl/mul_seq_unit_pkg.sv
// Shared definitions for the sequential multiplier: FSM state
// encoding and per-build step width / step count. Build macro: MUL_RADIX4_EN.
package mul_seq_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

`ifdef MUL_RADIX4_EN
  localparam int STEP_BITS = 2;
`else
  localparam int STEP_BITS = 1;
`endif

  function automatic int step_count(input int width);
    return width / STEP_BITS;
  endfunction

endpackage

// File: rtl/mul_seq_unit_pp_select.sv
// Partial-product selector: picks 0, A, 2A or 3A by a 2-bit selector.
// Ports: a, a2, a3 (candidates), sel (selector), pp (partial product).
module mul_pp_select #(
  parameter int PW = 32
) (
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] a2,
  input  logic [PW-1:0] a3,
  input  logic [1:0]    sel,
  output logic [PW-1:0] pp
);

  always_comb begin
    pp = '0;
    unique case (sel)
      2'd0: pp = '0;
      2'd1: pp = a;
      2'd2: pp = a2;
      2'd3: pp = a3;
    endcase
  end

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential shift-add unsigned multiplier, radix-2 or radix-4 (MUL_RADIX4_EN).
// Ports: Clock, Reset (sync, active-high), iStart/iA/iB request,
// oBusy, oDone (1-cycle pulse), oResult (held until next result).
module mul_seq_unit
  import mul_seq_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oResult
);

  localparam int PW = 2 * WIDTH;
  localparam int N  = step_count(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  if (WIDTH % 2 != 0) begin : g_width_chk
    $error("WIDTH must be even");
  end

  state_t          state;
  logic [PW-1:0]   a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   res_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;

  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   a2;
  logic [PW-1:0]   a3;
  logic [PW-1:0]   pp;
  logic [1:0]      sel;

  assign a_ext = {{WIDTH{1'b0}}, iA};
  assign a2    = a_q << 1;

`ifdef MUL_RADIX4_EN
  // 3A is built once at accept and shifted alongside A.
  logic [PW-1:0] a3_q;
  assign a3  = a3_q;
  assign sel = b_q[1:0];
`else
  assign a3  = '0;
  assign sel = {1'b0, b_q[0]};
`endif

  mul_pp_select #(
    .PW (PW)
  ) u_pp (
    .a   (a_q),
    .a2  (a2),
    .a3  (a3),
    .sel (sel),
    .pp  (pp)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MUL_RADIX4_EN
      a3_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (iStart) begin
            state  <= S_RUN;
            busy_q <= 1'b1;
            a_q    <= a_ext;
            b_q    <= iB;
            acc_q  <= '0;
            cnt_q  <= N_CNT;
`ifdef MUL_RADIX4_EN
            a3_q   <= a_ext + (a_ext << 1);
`endif
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          // N step cycles, then one cycle to publish the sum.
          if (cnt_q != '0) begin
            acc_q <= acc_q + pp;
            a_q   <= a_q << STEP_BITS;
            b_q   <= b_q >> STEP_BITS;
            cnt_q <= cnt_q - CW'(1);
`ifdef MUL_RADIX4_EN
            a3_q  <= a3_q << STEP_BITS;
`endif
          end else begin
            state  <= S_DONE;
            done_q <= 1'b1;
            res_q  <= acc_q;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oResult = res_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit (WIDTH=16), either build.
// Directed vectors plus a few random products against a reference.
module tb_mul_seq_unit;

`ifdef MUL_RADIX4_EN
  localparam int N = 8;
`else
  localparam int N = 16;
`endif
  localparam int LAT = N + 1;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iStart = 1'b0;
  logic [15:0] iA = '0;
  logic [15:0] iB = '0;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;

  int checks = 0;
  int errors = 0;

  mul_seq_unit #(
    .WIDTH (16)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iA      (iA),
    .iB      (iB),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oResult (oResult)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    iA = a;
    iB = b;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
  endtask

  // Called just after the accepting edge; counts edges until oDone.
  task automatic wait_done(input logic [31:0] prev, output int cyc,
                           output int busy_cnt, output bit held);
    cyc = 0;
    busy_cnt = oBusy ? 1 : 0;
    held = (oResult === prev);
    for (int i = 0; i < 200; i++) begin
      step();
      cyc++;
      if (oDone) break;
      if (oBusy) busy_cnt++;
      if (oResult !== prev) held = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp);
    int cyc;
    int bc;
    bit held;
    logic [31:0] prev;
    prev = oResult;
    launch(a, b);
    wait_done(prev, cyc, bc, held);
    chk({tag, "_lat"}, cyc, LAT);
    chk({tag, "_res"}, oResult, exp);
    chk({tag, "_busy"}, bc, LAT);
    chk({tag, "_held"}, held, 1);
    step();
    chk({tag, "_done_lo"}, oDone, 0);
    chk({tag, "_idle"}, oBusy, 0);
  endtask

  initial begin
    int cyc;
    int bc;
    int dn;
    bit held;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] rexp;

    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_res", oResult, 0);

    run_op("m3x5", 16'd3, 16'd5, 32'h0000000F);
    run_op("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op("m0", 16'h0000, 16'h1234, 32'h00000000);
    run_op("m8000", 16'h8000, 16'h0002, 32'h00010000);
    run_op("mff0101", 16'h00FF, 16'h0101, 32'h0000FFFF);

    // Re-pulse during RUN must be ignored.
    launch(16'h0100, 16'h0010);
    step();
    step();
    iA = 16'd7;
    iB = 16'd7;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    wait_done(32'h00010000, cyc, bc, held);
    chk("rp_lat", cyc, LAT - 3);
    chk("rp_res", oResult, 32'h00001000);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (oDone) dn++;
    end
    chk("rp_no_2nd", dn, 0);
    chk("rp_keep", oResult, 32'h00001000);

    // Reset four cycles into RUN aborts the request.
    launch(16'd3, 16'd5);
    step();
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("ab_busy", oBusy, 0);
    chk("ab_res", oResult, 0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (oDone || oBusy) dn++;
    end
    chk("ab_quiet", dn, 0);

    // Reset wins over a same-cycle start.
    iA = 16'd3;
    iB = 16'd5;
    iStart = 1'b1;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    iStart = 1'b0;
    chk("rp_pri_busy", oBusy, 0);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (oDone || oBusy) dn++;
    end
    chk("rp_pri_quiet", dn, 0);

    // Back-to-back accept from DONE.
    launch(16'h0011, 16'h0011);
    wait_done(32'h0, cyc, bc, held);
    chk("bb1_lat", cyc, LAT);
    chk("bb1_res", oResult, 32'h00000121);
    iA = 16'd2;
    iB = 16'd9;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    chk("bb_busy", oBusy, 1);
    wait_done(32'h00000121, cyc, bc, held);
    chk("bb2_lat", cyc, LAT);
    chk("bb2_res", oResult, 32'h00000012);
    chk("bb2_held", held, 1);
    step();
    chk("bb2_idle", oBusy, 0);

    for (int k = 0; k < 8; k++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rexp = 32'(ra) * 32'(rb);
      run_op($sformatf("rnd%0d", k), ra, rb, rexp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
